// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Operations are accepted through a start/busy/done handshake. Each one
// runs 32 shift-add or restoring-divide iterations on the operand
// magnitudes, followed by one sign-correction cycle. Result is registered.
// Optional build macro: MULDIV_EARLY_OUT_EN. When it is defined, divide by
// zero, signed divide overflow and multiplies with a zero operand skip the
// iterations and finish one cycle after they are accepted.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic        Zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_REM  = 3'b110;

    state_t      state_reg;
    logic [2:0]  op_reg;
    logic [31:0] a_mag_reg;
    logic [31:0] b_mag_reg;
    logic        neg_prod_reg;
    logic        neg_quot_reg;
    logic        neg_rem_reg;
    logic [4:0]  count_reg;
    logic [63:0] acc_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [31:0] result_reg;

    // Accept-time decode
    logic        a_signed;
    logic        b_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] start_acc;
    state_t      start_state;

    // Iteration datapath
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;

    // Sign correction and result selection
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_result;

    // Operand sign handling and the accumulator/state loaded on accept
    always_comb begin
        // MULH, MULHSU, DIV and REM treat A as signed; only MULH, DIV and REM treat B as signed.
        // MUL takes the low product word, which does not depend on signedness.
        a_signed = (Op == 3'b001) || (Op == 3'b010) || (Op == OP_DIV) || (Op == OP_REM);
        b_signed = (Op == 3'b001) || (Op == OP_DIV) || (Op == OP_REM);
        a_neg    = a_signed & A[31];
        b_neg    = b_signed & B[31];
        a_mag    = a_neg ? (~A + 32'd1) : A;
        b_mag    = b_neg ? (~B + 32'd1) : B;
        // Multiply shifts the multiplier out of the low half; divide shifts the dividend out of it
        start_acc   = Op[2] ? {32'd0, a_mag} : {32'd0, b_mag};
        start_state = CALC;
`ifdef MULDIV_EARLY_OUT_EN
        // Preload the accumulator with what the iterations would have produced
        if (Op[2] && (B == 32'd0)) begin
            start_acc   = {a_mag, 32'hFFFF_FFFF};
            start_state = FIXUP;
        end else if (((Op == OP_DIV) || (Op == OP_REM)) &&
                     (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
            start_acc   = {32'd0, 32'h8000_0000};
            start_state = FIXUP;
        end else if (!Op[2] && ((A == 32'd0) || (B == 32'd0))) begin
            start_acc   = 64'd0;
            start_state = FIXUP;
        end
`endif
    end

    // One shift-add multiply step and one restoring divide step per cycle
    always_comb begin
        mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, a_mag_reg} : 33'd0);
        mul_next  = {mul_sum, acc_reg[31:1]};
        div_shift = {acc_reg[63:32], acc_reg[31]};
        div_diff  = div_shift - {1'b0, b_mag_reg};
        div_ge    = (div_shift >= {1'b0, b_mag_reg});
        div_next  = div_ge ? {div_diff[31:0], acc_reg[30:0], 1'b1}
                           : {div_shift[31:0], acc_reg[30:0], 1'b0};
    end

    // Sign correction of the magnitude results and final word selection
    always_comb begin
        prod_fix = neg_prod_reg ? (~acc_reg + 64'd1) : acc_reg;
        quot_fix = neg_quot_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
        rem_fix  = neg_rem_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];
        case (op_reg)
            OP_MUL:                 fix_result = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[63:32];
            3'b100, 3'b101:         fix_result = quot_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    // Control FSM with registered handshake outputs and result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            op_reg       <= 3'd0;
            a_mag_reg    <= 32'd0;
            b_mag_reg    <= 32'd0;
            neg_prod_reg <= 1'b0;
            neg_quot_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            count_reg    <= 5'd0;
            acc_reg      <= 64'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            result_reg   <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg       <= Op;
                        a_mag_reg    <= a_mag;
                        b_mag_reg    <= b_mag;
                        neg_prod_reg <= a_neg ^ b_neg;
                        // A zero divisor yields all ones regardless of operand signs
                        neg_quot_reg <= (a_neg ^ b_neg) & (B != 32'd0);
                        neg_rem_reg  <= a_neg;
                        count_reg    <= 5'd0;
                        acc_reg      <= start_acc;
                        busy_reg     <= 1'b1;
                        state_reg    <= start_state;
                    end
                end
                CALC: begin
                    acc_reg   <= op_reg[2] ? div_next : mul_next;
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        state_reg <= FIXUP;
                    end
                end
                FIXUP: begin
                    result_reg <= fix_result;
                    done_reg   <= 1'b1;
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign Result = result_reg;
    assign Zero   = (result_reg == 32'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Directed RV32M cases
// plus randomized operations, compared against an arithmetic reference model.
// Honours MULDIV_EARLY_OUT_EN when deciding the expected latency.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic        Zero;

    int vectors;
    int miscompares;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .Zero   (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain 64-bit and signed 32-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa;
        logic [63:0] ua;
        logic [63:0] sb;
        logic [63:0] ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        int          r;
        sa = {{32{a[31]}}, a};
        ua = {32'd0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        p  = 64'd0;
        r  = 0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = ia / ib;
                return r;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                r = ia % ib;
                return r;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (op[2] && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (!op[2] && (a == 32'd0 || b == 32'd0)) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Reset for two cycles, then check reset values; ends 1 time unit after an edge
    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        Op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_value("reset_busy", busy, 0);
        check_value("reset_done", done, 0);
        check_value("reset_result", Result, 32'd0);
        check_value("reset_zero", Zero, 1);
    endtask

    // Issue one operation and check result, Zero and latency. Must be called
    // 1 time unit after a rising edge. poke>0 pulses start with junk operands
    // during busy at that cycle. Returns 1 time unit after the done edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int poke);
        logic [31:0] exp;
        int          lat;
        int          want;
        bit          seen;
        exp  = ref_model(op, a, b);
        want = exp_latency(op, a, b);
        start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        Op    = 3'($urandom);
        A     = $urandom;
        B     = $urandom;
        check_value("busy_after_accept", busy, 1);
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (poke > 0 && c == poke) begin
                start = 1'b1;
                Op    = 3'($urandom);
                A     = $urandom;
                B     = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!seen) begin
            check_value("done_timeout", 0, 1);
        end else begin
            check_value("latency", lat, want);
            check_value("result", Result, exp);
            check_value("zero", Zero, (exp == 32'd0) ? 1 : 0);
            check_value("busy_at_done", busy, 0);
        end
        $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d", op, a, b, Result, exp, lat);
    endtask

    initial begin
        logic [31:0] held;
        bit          done_seen;
        vectors     = 0;
        miscompares = 0;

        do_reset();

        // Directed arithmetic cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'd7, 32'd2, 0);
        run_op(3'd5, 32'd5, 32'd0, 0);
        run_op(3'd7, 32'd5, 32'd0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(3'd1, 32'd0, 32'hFFFF_FFFB, 0);

        // done is a single-cycle pulse and Result holds afterwards
        held = Result;
        @(posedge clk);
        #1;
        check_value("done_pulse_width", done, 0);
        check_value("result_hold", Result, held);

        // start during busy is ignored
        run_op(3'd5, 32'd100, 32'd7, 5);

        // back-to-back: second start issued in the done cycle
        run_op(3'd0, 32'd12345, 32'd678, 0);
        run_op(3'd7, 32'd12345, 32'd678, 0);

        // reset in the middle of CALC aborts the operation
        start = 1'b1;
        Op    = 3'd0;
        A     = 32'd5;
        B     = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_value("abort_busy", busy, 0);
        check_value("abort_done", done, 0);
        check_value("abort_result", Result, 32'd0);
        check_value("abort_zero", Zero, 1);
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        check_value("abort_no_done", done_seen, 0);
        run_op(3'd0, 32'd3, 32'd4, 0);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 0);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
